// File: rtl/hilo_md_unit_pkg.sv
// Shared constants and types for the E-stage multiply/divide unit.
// Holds the op encoding, default latencies, FSM states and the result payload.
package hilo_md_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // wr clear means the commit must leave HI/LO untouched (divide by zero).
  typedef struct packed {
    logic            wr;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

endpackage

// File: rtl/hilo_md_unit_md_arith.sv
// Combinational multiply/divide datapath producing the {HI,LO} result for one op.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps without a trap.
module hilo_md_unit_md_arith
  import hilo_md_unit_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output md_result_t      res_c
);

  logic signed [2*XLEN-1:0] a_sx;
  logic signed [2*XLEN-1:0] b_sx;
  logic        [2*XLEN-1:0] prod_s;
  logic        [2*XLEN-1:0] prod_u;
  logic        [XLEN-1:0]   mag_a;
  logic        [XLEN-1:0]   mag_b;
  logic        [XLEN-1:0]   quo_m;
  logic        [XLEN-1:0]   rem_m;
  logic        [XLEN-1:0]   quo_s;
  logic        [XLEN-1:0]   rem_s;
  logic        [XLEN-1:0]   quo_u;
  logic        [XLEN-1:0]   rem_u;
  logic                     b_zero;

  assign a_sx   = {{XLEN{a[XLEN-1]}}, a};
  assign b_sx   = {{XLEN{b[XLEN-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  assign b_zero = (b == '0);
  assign mag_a  = a[XLEN-1] ? (XLEN'(0) - a) : a;
  assign mag_b  = b[XLEN-1] ? (XLEN'(0) - b) : b;
  assign quo_m  = b_zero ? '0 : mag_a / mag_b;
  assign rem_m  = b_zero ? '0 : mag_a % mag_b;
  // Quotient sign follows operand signs; remainder sign follows the dividend.
  assign quo_s  = (a[XLEN-1] ^ b[XLEN-1]) ? (XLEN'(0) - quo_m) : quo_m;
  assign rem_s  = a[XLEN-1] ? (XLEN'(0) - rem_m) : rem_m;
  assign quo_u  = b_zero ? '0 : a / b;
  assign rem_u  = b_zero ? '0 : a % b;

  always_comb begin
    res_c = '0;
    case (op)
      MD_MULT:  begin res_c.wr = 1'b1;    {res_c.hi, res_c.lo} = prod_s; end
      MD_MULTU: begin res_c.wr = 1'b1;    {res_c.hi, res_c.lo} = prod_u; end
      MD_DIV:   begin res_c.wr = !b_zero; res_c.hi = rem_s; res_c.lo = quo_s; end
      MD_DIVU:  begin res_c.wr = !b_zero; res_c.hi = rem_u; res_c.lo = quo_u; end
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/hilo_md_unit.sv
// E-stage multi-cycle multiply/divide unit owning architectural HI/LO.
// Result is captured into a shadow at issue and committed after the op latency.
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_result_t      shadow_q, shadow_d;
  md_result_t      arith_res_c;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            issue_c;

  hilo_md_unit_md_arith u_arith (
    .op    (op),
    .a     (src_a),
    .b     (src_b),
    .res_c (arith_res_c)
  );

  assign issue_c = start && !cancel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi       <= hi_d;
      lo       <= lo_d;
      busy     <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi;
    lo_d     = lo;
    case (state_q)
      ST_IDLE: begin
        if (issue_c) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              shadow_d = arith_res_c;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              shadow_d = arith_res_c;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = ST_RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Cancel beats commit, even on the final cycle.
        if (cancel) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (shadow_q.wr) begin
            hi_d = shadow_q.hi;
            lo_d = shadow_q.lo;
          end
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed vector table, corner sequences
// and randomized ops checked against a plain-arithmetic reference model.
module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return 5;
    if (o == 3'd2 || o == 3'd3) return 10;
    return 0;
  endfunction

  // Reference model: integer arithmetic on 64-bit values, division truncates toward zero.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub;      h = p[63:32]; l = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; h = 32'(r); l = 32'(q); end
      3'd3: if (b != 0) begin h = 32'(ua % ub); l = 32'(ua / ub); end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  task automatic apply(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] ph, pl;
    int n;
    bit early;
    n = 0;
    early = 1'b0;
    @(negedge clk);
    ph = hi;
    pl = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 100) begin
      if (hi !== ph || lo !== pl) early = 1'b1;
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(n), 64'(exp_cycles(o)));
    if (o < 3'd4) check({name, " early_change"}, 64'(early), 64'(0));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " idle_timeout"}, 64'(busy), 64'(0));
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eh, el;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; cancel = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi",   64'(hi),   64'(0));
    check("reset lo",   64'(lo),   64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    vecs.push_back('{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"div_neg",    3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_zero",  3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{"mthi",       3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000});
    vecs.push_back('{"mtlo",       3'd5, 32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D});
    vecs.push_back('{"op6_rsvd",   3'd6, 32'h00000001, 32'h00000002, 32'h12345678, 32'hCAFEF00D});
    vecs.push_back('{"divu_rem",   3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});
    vecs.push_back('{"div_negdiv", 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"mult_min",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"multu_pow",  3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    foreach (vecs[i]) apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

    // MTLO/MTHI issued while a MULT runs must be ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'h00000003; src_b = 32'hFFFFFFFB;
    @(negedge clk);
    op = 3'd5; src_a = 32'hDEADBEEF;
    @(negedge clk);
    op = 3'd4; src_a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mtlo_in_run");
    check("mtlo_in_run hi", 64'(hi), 64'h00000000FFFFFFFF);
    check("mtlo_in_run lo", 64'(lo), 64'h00000000FFFFFFF1);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;

    // DIV cancelled on its fourth busy cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("cancel_div busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_div busy_after", 64'(busy), 64'(0));
    check("cancel_div hi", 64'(hi), 64'(m_hi));
    check("cancel_div lo", 64'(lo), 64'(m_lo));
    apply("mult_after_cancel", 3'd0, 32'd6, 32'd7, 32'd0, 32'h2A);

    // Cancel in the commit cycle suppresses the commit.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("cancel_commit busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_commit busy", 64'(busy), 64'(0));
    check("cancel_commit lo", 64'(lo), 64'(m_lo));

    // start together with cancel is dropped, including MTHI.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("start_cancel busy", 64'(busy), 64'(0));
    op = 3'd4; src_a = 32'h55AA55AA;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("mthi_cancel hi", 64'(hi), 64'(m_hi));

    // Asynchronous reset between edges in the middle of a MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset busy", 64'(busy), 64'(0));
    check("async_reset hi",   64'(hi),   64'(0));
    check("async_reset lo",   64'(lo),   64'(0));
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    start = 1'b1; cancel = 1'b1; op = 3'd5; src_a = 32'h77777777;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("post_reset_cancel busy", 64'(busy), 64'(0));
    check("post_reset_cancel lo",   64'(lo),   64'(0));

    // Randomized ops against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      eh = m_hi;
      el = m_lo;
      ref_md(ro, ra, rb, eh, el);
      apply($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb, eh, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Multi-cycle multiply/divide unit for the 5-stage MIPS core; sits in E stage and owns the HI/LO architectural registers.
- Produces the HILO value carried E→M→W through the pipeline registers to writeback (mfhi/mflo).
- Exposes busy so the hazard unit stalls md instructions and mfhi/mflo while an operation is in flight.
- Supports cancel of an in-flight operation on a CP0 exception flush.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (reset==0 resets)
- start  input  1  E-stage md instruction valid this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- src_a  input  32  rs value (forwarded)
- src_b  input  32  rt value (forwarded)
- cancel  input  1  exception flush from CP0; abandons in-flight op
- busy  output  1  operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, reset==0): hi=0, lo=0, busy=0, counter=0, shadow regs=0; takes effect immediately, independent of clk.
- Reset mid-operation: operation is lost; hi/lo return to 0.
- States: IDLE, RUN.
- IDLE, start=1, cancel=0, op∈{0..3}:
  - Compute result at this edge into shadow_hi/shadow_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, cancel=0, op=4 or 5:
  - hi (op 4) or lo (op 5) takes src_a at this edge.
  - busy stays 0; stays in IDLE.
- op 6/7: ignored.
- RUN:
  - Counter decrements each cycle.
  - On the cycle counter==1, next edge commits shadow to hi/lo, busy→0, state→IDLE.
  - Total latency: start edge + N cycles. hi/lo change exactly N edges after the start edge.
- start while busy=1: ignored. The hazard unit guarantees no issue; no error reporting.
- cancel=1 in RUN: next edge goes to IDLE, busy→0, hi/lo unchanged, shadow discarded.
- cancel=1 with start=1 in the same cycle: start ignored; MTHI/MTLO also suppressed.
- cancel=1 in the commit cycle (counter==1): cancel wins; no commit.
- Arithmetic:
  - MULT: signed 32×32→64, {hi,lo}=product.
  - MULTU: same, unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder, sign of dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (src_b==0): goes busy for DIV_CYCLES as normal, but commit leaves hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- hi/lo are registered outputs only; no bypass of shadow values. mfhi/mflo must stall while busy=1.

Decomposition:
- Shared package (with the existing pipeline constants):
  - op encoding constants MD_MULT..MD_MTLO
  - default cycle counts
  - state encoding IDLE/RUN
- One natural sub-module, md_arith: combinational signed/unsigned mul/div datapath producing {res_hi,res_lo}.
- Control FSM, counter and HI/LO registers stay in hilo_md_unit.

Test Plan:
- MULT, a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged before the 5th edge.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV:
  - a=-7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → busy 10 cycles, hi/lo keep prior values.
- MTHI a=0x12345678 → hi=0x12345678 next edge, busy never asserts. Then MTLO during RUN of a MULT → ignored; MULT result committed.
- DIV started, cancel pulsed at cycle 4 → busy falls next edge; hi/lo unchanged. A new MULT issued the following cycle completes normally.
- Mid-RUN of MULT, assert reset=0 between clock edges → hi=lo=0, busy=0 immediately. After release, start with cancel=1 → no state change.
